// File: rtl/vga_rect_layer_if.sv
// Bus bundle for the rectangle overlay layer: shadow-register write port,
// pixel stream in, and the registered per-pixel overlay result out.
interface vga_rect_layer_if #(
    parameter int unsigned NUM_RECTS = 4,
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned COLOR_W   = 9
);
    localparam int unsigned IDX_W = $clog2(NUM_RECTS);

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [1:0]             wr_field;
    logic [2*COORD_W-1:0]   wr_data;
    logic                   frame_start;
    logic                   pix_valid;
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic                   out_valid;
    logic                   show;
    logic [COLOR_W-1:0]     color_out;
    logic [IDX_W-1:0]       hit_idx;

    modport master (
        output wr_en, wr_idx, wr_field, wr_data, frame_start, pix_valid, x, y,
        input  out_valid, show, color_out, hit_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_field, wr_data, frame_start, pix_valid, x, y,
        output out_valid, show, color_out, hit_idx
    );
endinterface

// File: rtl/vga_rect_layer.sv
// Rectangle overlay: double-buffered rectangle slots committed at frame start,
// two-stage hit-test pipeline with lowest-index priority.
module vga_rect_layer #(
    parameter int unsigned NUM_RECTS = 4,
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned COLOR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    vga_rect_layer_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NUM_RECTS);
    localparam int unsigned SW    = COORD_W + 2;

    typedef struct packed {
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] colour;
        logic               en;
    } slot_t;

    slot_t                shadow [NUM_RECTS];
    slot_t                active [NUM_RECTS];

    logic [NUM_RECTS-1:0] hit_c;
    logic [NUM_RECTS-1:0] hit_q;
    logic [COLOR_W-1:0]   colour_q [NUM_RECTS];
    logic                 valid_q;

    logic                 win_c;
    logic [IDX_W-1:0]     win_idx_c;
    logic [COLOR_W-1:0]   win_col_c;

    logic                 out_valid_q;
    logic                 show_q;
    logic [COLOR_W-1:0]   color_q;
    logic [IDX_W-1:0]     hit_idx_q;

    // Strict inside test on signed bounds wide enough that edges never wrap.
    function automatic logic slot_hit(slot_t s, logic [COORD_W-1:0] px, logic [COORD_W-1:0] py);
        logic signed [SW-1:0] l, r, t, b, sx, sy;
        sx = $signed(SW'(px));
        sy = $signed(SW'(py));
        l  = $signed(SW'(s.cx)) - $signed(SW'(s.w >> 1));
        r  = $signed(SW'(s.cx)) + $signed(SW'(s.w >> 1));
        t  = $signed(SW'(s.cy)) - $signed(SW'(s.h >> 1));
        b  = $signed(SW'(s.cy)) + $signed(SW'(s.h >> 1));
        return s.en && (s.w >= COORD_W'(2)) && (s.h >= COORD_W'(2)) &&
               (sx > l) && (sx < r) && (sy > t) && (sy < b);
    endfunction

    // Shadow writes and frame-start commit; commit samples pre-write shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_RECTS); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (bus.frame_start) begin
                for (int i = 0; i < int'(NUM_RECTS); i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (bus.wr_en) begin
                for (int i = 0; i < int'(NUM_RECTS); i++) begin
                    if (bus.wr_idx == IDX_W'(i)) begin
                        case (bus.wr_field)
                            2'd0: begin
                                shadow[i].cx <= bus.wr_data[2*COORD_W-1:COORD_W];
                                shadow[i].cy <= bus.wr_data[COORD_W-1:0];
                            end
                            2'd1: begin
                                shadow[i].w <= bus.wr_data[2*COORD_W-1:COORD_W];
                                shadow[i].h <= bus.wr_data[COORD_W-1:0];
                            end
                            2'd2: shadow[i].colour <= bus.wr_data[COLOR_W-1:0];
                            2'd3: shadow[i].en     <= bus.wr_data[0];
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(NUM_RECTS); i++) begin
            hit_c[i] = slot_hit(active[i], bus.x, bus.y);
        end
    end

    // Stage 1 also snapshots colours so a commit mid-pipeline cannot recolour a pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_RECTS); i++) begin
                colour_q[i] <= '0;
            end
        end else begin
            hit_q   <= hit_c;
            valid_q <= bus.pix_valid;
            for (int i = 0; i < int'(NUM_RECTS); i++) begin
                colour_q[i] <= active[i].colour;
            end
        end
    end

    // Lowest index wins: scan downward so the last assignment is the lowest hit.
    always_comb begin
        win_c     = 1'b0;
        win_idx_c = '0;
        win_col_c = '0;
        for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                win_c     = 1'b1;
                win_idx_c = IDX_W'(i);
                win_col_c = colour_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            show_q      <= 1'b0;
            color_q     <= '0;
            hit_idx_q   <= '0;
        end else begin
            out_valid_q <= valid_q;
            show_q      <= valid_q && win_c;
            color_q     <= (valid_q && win_c) ? win_col_c : '0;
            hit_idx_q   <= (valid_q && win_c) ? win_idx_c : '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.show      = show_q;
    assign bus.color_out = color_q;
    assign bus.hit_idx   = hit_idx_q;
endmodule

// File: tb/tb_vga_rect_layer.sv
// Self-checking bench for vga_rect_layer: directed scenarios plus random
// traffic compared every cycle against an array-based reference model.
module tb_vga_rect_layer;
    localparam int N  = 4;
    localparam int CW = 11;
    localparam int KW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_rect_layer_if #(.NUM_RECTS(N), .COORD_W(CW), .COLOR_W(KW)) bus ();

    vga_rect_layer #(.NUM_RECTS(N), .COORD_W(CW), .COLOR_W(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    int s_cx[N], s_cy[N], s_w[N], s_h[N], s_col[N], s_en[N];
    int a_cx[N], a_cy[N], a_w[N], a_h[N], a_col[N], a_en[N];
    int e1_v, e1_s, e1_c, e1_i;
    int e2_v, e2_s, e2_c, e2_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            s_cx[i] = 0; s_cy[i] = 0; s_w[i] = 0; s_h[i] = 0; s_col[i] = 0; s_en[i] = 0;
            a_cx[i] = 0; a_cy[i] = 0; a_w[i] = 0; a_h[i] = 0; a_col[i] = 0; a_en[i] = 0;
        end
        e1_v = 0; e1_s = 0; e1_c = 0; e1_i = 0;
        e2_v = 0; e2_s = 0; e2_c = 0; e2_i = 0;
    endtask

    // Overlay result of one pixel from the committed rectangles.
    task automatic model_pixel(input int px, input int py, input int pv,
                               output int v, output int s, output int c, output int idx);
        v = pv; s = 0; c = 0; idx = 0;
        if (pv != 0) begin
            for (int i = 0; i < N; i++) begin
                if (s == 0 && a_en[i] != 0 && a_w[i] >= 2 && a_h[i] >= 2 &&
                    px > a_cx[i] - a_w[i] / 2 && px < a_cx[i] + a_w[i] / 2 &&
                    py > a_cy[i] - a_h[i] / 2 && py < a_cy[i] + a_h[i] / 2) begin
                    s = 1; c = a_col[i]; idx = i;
                end
            end
        end
    endtask

    task automatic model_edge();
        int v, s, c, idx, d;
        if (!rst) begin
            model_clear();
            return;
        end
        model_pixel(int'(bus.x), int'(bus.y), int'(bus.pix_valid), v, s, c, idx);
        e2_v = e1_v; e2_s = e1_s; e2_c = e1_c; e2_i = e1_i;
        e1_v = v;    e1_s = s;    e1_c = c;    e1_i = idx;
        if (bus.frame_start) begin
            for (int i = 0; i < N; i++) begin
                a_cx[i] = s_cx[i]; a_cy[i] = s_cy[i]; a_w[i] = s_w[i];
                a_h[i] = s_h[i]; a_col[i] = s_col[i]; a_en[i] = s_en[i];
            end
        end
        if (bus.wr_en && int'(bus.wr_idx) < N) begin
            d = int'(bus.wr_data);
            case (bus.wr_field)
                2'd0: begin s_cx[bus.wr_idx] = (d >> CW) & 'h7FF; s_cy[bus.wr_idx] = d & 'h7FF; end
                2'd1: begin s_w[bus.wr_idx]  = (d >> CW) & 'h7FF; s_h[bus.wr_idx]  = d & 'h7FF; end
                2'd2: s_col[bus.wr_idx] = d & 'h1FF;
                default: s_en[bus.wr_idx] = d & 1;
            endcase
        end
    endtask

    task automatic compare();
        check("out_valid", 32'(bus.out_valid), 32'(e2_v));
        check("show",      32'(bus.show),      32'(e2_s));
        check("color_out", 32'(bus.color_out), 32'(e2_c));
        check("hit_idx",   32'(bus.hit_idx),   32'(e2_i));
    endtask

    // One clock: inputs set beforehand at the falling edge, checked 1 after the rising edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1 compare();
        @(negedge clk);
        bus.wr_en = 1'b0; bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
    endtask

    task automatic wr(input int idx, input int field, input int data);
        bus.wr_en = 1'b1; bus.wr_idx = 2'(idx); bus.wr_field = 2'(field); bus.wr_data = 22'(data);
        tick();
    endtask

    task automatic commit();
        bus.frame_start = 1'b1;
        tick();
    endtask

    task automatic pix(input int px, input int py);
        bus.pix_valid = 1'b1; bus.x = 11'(px); bus.y = 11'(py);
        tick();
    endtask

    task automatic program_slot(input int idx, input int cx, input int cy,
                                input int w, input int h, input int col, input int en);
        wr(idx, 0, (cx << CW) | cy);
        wr(idx, 1, (w << CW) | h);
        wr(idx, 2, col);
        wr(idx, 3, en);
    endtask

    // Directed probe with hand-derived constants, independent of the model.
    task automatic probe(input string tag, input int px, input int py,
                         input int s, input int c, input int idx);
        pix(px, py);
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_show"},  32'(bus.show),      32'(s));
        check({tag, "_color"}, 32'(bus.color_out), 32'(c));
        check({tag, "_idx"},   32'(bus.hit_idx),   32'(idx));
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_field = '0; bus.wr_data = '0;
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.x = '0; bus.y = '0;
        model_clear();
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single rectangle: x bounds 90..110 exclusive
        program_slot(0, 100, 100, 20, 10, 'h1C0, 1);
        commit();
        probe("r30_in", 95, 100, 1, 'h1C0, 0);
        probe("r30_edge", 90, 100, 0, 0, 0);

        // Overlap priority
        program_slot(1, 100, 100, 40, 40, 'h007, 1);
        commit();
        probe("r31_both", 100, 100, 1, 'h1C0, 0);
        probe("r31_slot1", 115, 100, 1, 'h007, 1);

        // Double buffering
        wr(0, 2, 'h038);
        probe("r32_pre", 100, 100, 1, 'h1C0, 0);
        commit();
        probe("r32_post", 100, 100, 1, 'h038, 0);
        bus.frame_start = 1'b1;
        wr(0, 2, 'h1C0);
        probe("r32_same", 100, 100, 1, 'h038, 0);
        commit();
        probe("r32_next", 100, 100, 1, 'h1C0, 0);

        // Screen-edge rectangles and degenerate size
        wr(1, 3, 0);
        program_slot(0, 3, 3, 20, 20, 'h1C0, 1);
        commit();
        probe("r33_origin", 0, 0, 1, 'h1C0, 0);
        wr(0, 0, (2045 << CW) | 2045);
        commit();
        probe("r33_max", 2047, 2047, 1, 'h1C0, 0);
        wr(0, 1, (1 << CW) | 5);
        commit();
        probe("r33_thin", 2045, 2045, 0, 0, 0);
        probe("r33_thin2", 2044, 2046, 0, 0, 0);

        // Toggling valid stream
        wr(0, 1, (20 << CW) | 20);
        commit();
        for (int k = 0; k < 8; k++) begin
            bus.pix_valid = (k % 2 == 0); bus.x = 11'(2040 + k); bus.y = 11'(2045);
            tick();
        end
        repeat (2) tick();

        // Reset mid-stream
        for (int k = 0; k < 3; k++) begin
            bus.pix_valid = 1'b1; bus.x = 11'(2045); bus.y = 11'(2045);
            tick();
        end
        rst = 1'b0;
        bus.pix_valid = 1'b1;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_show",  32'(bus.show),      32'd0);
        check("rst_color", 32'(bus.color_out), 32'd0);
        check("rst_idx",   32'(bus.hit_idx),   32'd0);
        tick();
        rst = 1'b1;
        commit();
        probe("r35_after", 2045, 2045, 0, 0, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                int f;
                f = int'($urandom_range(0, 3));
                bus.wr_en = 1'b1; bus.wr_idx = 2'($urandom_range(0, 3)); bus.wr_field = 2'(f);
                case (f)
                    0: bus.wr_data = 22'(($urandom_range(0, 250) << CW) | $urandom_range(0, 250));
                    1: bus.wr_data = 22'(($urandom_range(0, 150) << CW) | $urandom_range(0, 150));
                    2: bus.wr_data = 22'($urandom_range(0, 511));
                    default: bus.wr_data = 22'($urandom_range(0, 3) != 0);
                endcase
            end
            bus.frame_start = ($urandom_range(0, 11) == 0);
            bus.pix_valid = ($urandom_range(0, 3) != 0);
            bus.x = 11'($urandom_range(0, 260));
            bus.y = 11'($urandom_range(0, 260));
            tick();
        end
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_rect_layer.md
VGA_RECT_LAYER -- requirements
Module: vga_rect_layer

Interface
REQ-001 Parameter NUM_RECTS, default 4, is the number of rectangle slots (2..16).
REQ-002 Parameter COORD_W, default 11, is the coordinate and size width in bits.
REQ-003 Parameter COLOR_W, default 9, is the pixel colour width (RGB 3-3-3).
REQ-004 Local IDX_W SHALL be ceil(log2(NUM_RECTS)).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  1  shadow-register write strobe, one write per cycle.
REQ-008 wr_idx  input  IDX_W  slot written.
REQ-009 wr_field  input  2  0=center {x,y}, 1=size {w,h}, 2=colour, 3=ctrl (bit0 = slot enable).
REQ-010 wr_data  input  2*COORD_W  field payload: x/w in upper COORD_W, y/h in lower; colour in low COLOR_W bits.
REQ-011 frame_start  input  1  one-cycle pulse at start of vertical blank; commits shadow to active.
REQ-012 pix_valid  input  1  x/y qualify a visible pixel this cycle.
REQ-013 x, y  input  COORD_W each  current pixel coordinate.
REQ-014 out_valid  output  1  pix_valid delayed 2 cycles.
REQ-015 show  output  1  pixel lies inside at least one enabled active rectangle.
REQ-016 color_out  output  COLOR_W  colour of winning rectangle, 0 when show=0.
REQ-017 hit_idx  output  IDX_W  index of winning rectangle, 0 when show=0.

Function
REQ-018 Each slot SHALL hold a shadow set and an active set of {cx, cy, w, h, colour, en}.
REQ-019 wr_en SHALL update only the addressed field of the addressed shadow slot; wr_idx >= NUM_RECTS SHALL be ignored.
REQ-020 On frame_start all shadow sets SHALL copy to active sets in the same cycle; hit tests use only active sets.
REQ-021 wr_en and frame_start in the same cycle: active set SHALL receive the pre-write shadow value; the write lands in shadow and commits at the next frame_start.
REQ-022 Bounds SHALL be computed in COORD_W+2-bit signed arithmetic: L=cx-(w>>1), R=cx+(w>>1), T=cy-(h>>1), B=cy+(h>>1); no wrap-around.
REQ-023 Hit SHALL be en && x>L && x<R && y>T && y<B (strict); negative L/T therefore admit x=0/y=0, R/B beyond 2^COORD_W-1 admit the maximum coordinate.
REQ-024 w<2 or h<2 SHALL never hit.
REQ-025 Pipeline stage 1 SHALL register per-slot hit vector and pix_valid; stage 2 SHALL register priority result (lowest index wins), colour and out_valid; latency exactly 2 cycles, one pixel per cycle, no stalls.
REQ-026 When a stage-1 pixel has pix_valid=0, stage 2 SHALL force show=0, color_out=0, hit_idx=0.
REQ-027 frame_start mid-pipeline SHALL not alter results for pixels already in stage 1 (hit vector already registered).

Reset
REQ-028 While rst=0, all shadow and active fields SHALL be 0 (all slots disabled) and out_valid, show, color_out, hit_idx SHALL be 0.
REQ-029 Reset assertion mid-frame SHALL clear pipeline contents immediately; first valid output follows 2 cycles after first pix_valid after release.

Verification
REQ-030 Slot0 center (100,100), size (20,10), colour 0x1C0, en=1, frame_start; pixel (95,100) -> 2 cycles later show=1, color_out=0x1C0, hit_idx=0; pixel (90,100) -> show=0.
REQ-031 Slot1 (100,100,40,40,0x007) and slot0 as above, both enabled; pixel (100,100) -> hit_idx=0, colour 0x1C0; pixel (115,100) -> hit_idx=1, colour 0x007.
REQ-032 Rewrite slot0 colour to 0x038 without frame_start -> output colour stays 0x1C0; after frame_start -> 0x038; write coinciding with frame_start -> commits only at next frame_start.
REQ-033 Slot0 center (3,3) size (20,20) -> pixel (0,0) hits; center (2045,2045) size (20,20) -> pixel (2047,2047) hits; size (1,5) -> no hit anywhere.
REQ-034 Stream 8 consecutive pixels with pix_valid toggling -> out_valid reproduces pattern delayed 2 cycles; invalid slots show=0.
REQ-035 Assert rst mid-stream -> all outputs 0 immediately; after release all slots disabled, show=0 until reprogrammed and committed.
